// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage: owns the PC, reads program memory, hands instructions to decode
// One instruction in flight: REQ issues the read, CAPT takes the registered word, HOLD waits for the decoder.
module instr_fetch #(
  parameter int unsigned DATA_W    = 18,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned RESET_PC  = 0,
  parameter logic [DATA_W-1:0] HALT_WORD = 18'h3FFFF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic              mem_re_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_adrs,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted,
  output logic              busy,
  output logic [CNT_W-1:0]  fetch_cnt
);

  localparam logic [ADDR_W-1:0] RESET_ADRS = ADDR_W'(RESET_PC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAPT,
    S_HOLD,
    S_HALTED
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              xfer;

  // The memory address register is the PC itself, so the two can never disagree.
  assign mem_adrs = pc;
  assign xfer     = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_ADRS;
      mem_re_en   <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      busy        <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_REQ;
            pc        <= RESET_ADRS;
            mem_re_en <= 1'b1;
            busy      <= 1'b1;
          end
        end

        S_REQ: begin
          // A redirect here simply re-issues the read at the new target.
          if (redirect_valid) begin
            pc <= redirect_adrs;
          end else begin
            state     <= S_CAPT;
            mem_re_en <= 1'b0;
          end
        end

        S_CAPT: begin
          if (redirect_valid) begin
            pc        <= redirect_adrs;
            state     <= S_REQ;
            mem_re_en <= 1'b1;
          end else if (mem_rdata == HALT_WORD) begin
            state  <= S_HALTED;
            halted <= 1'b1;
            busy   <= 1'b0;
          end else begin
            instr       <= mem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= S_HOLD;
          end
        end

        S_HOLD: begin
          // A transfer coinciding with a redirect still counts; only the next PC changes.
          if (xfer || redirect_valid) begin
            if (xfer && (fetch_cnt != '1)) begin
              fetch_cnt <= fetch_cnt + 1'b1;
            end
            pc          <= redirect_valid ? redirect_adrs : pc + 1'b1;
            instr_valid <= 1'b0;
            state       <= S_REQ;
            mem_re_en   <= 1'b1;
          end
        end

        S_HALTED: begin
          mem_re_en <= 1'b0;
        end

        default: begin
          state     <= S_IDLE;
          mem_re_en <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the 18-bit program memory: owns the program counter and drives the memory's read address and read enable.
- Captures the memory's registered read data and presents each instruction with its address to the decoder over a valid/ready handshake.
- Supports branch redirect and stops on a halt word.
- Never writes memory; the memory's write enable stays with the loader path.

Parameters:
DATA_W, 18, instruction/memory word width
ADDR_W, 13, program address width
RESET_PC, 0, first fetch address after start
HALT_WORD, 18'h3FFFF, fetched word that stops the fetcher
CNT_W, 16, width of delivered-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin fetching at RESET_PC; sampled only in IDLE
mem_adrs  output  ADDR_W  read address to memory
mem_re_en  output  1  read enable to memory
mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_re_en
redirect_valid  input  1  branch taken; load PC from redirect_adrs
redirect_adrs  input  ADDR_W  branch target
instr  output  DATA_W  fetched instruction
instr_pc  output  ADDR_W  address of instr
instr_valid  output  1  instr/instr_pc valid
instr_ready  input  1  decoder accepts instruction
halted  output  1  HALT_WORD fetched
busy  output  1  state is not IDLE and not HALTED
fetch_cnt  output  CNT_W  instructions delivered since reset

Behaviour:
- Reset (async, immediate): state IDLE, pc=RESET_PC, mem_adrs=RESET_PC, mem_re_en=0, instr=0, instr_pc=0, instr_valid=0, halted=0, busy=0, fetch_cnt=0.
- All outputs are registered. mem_re_en is 1 only in state REQ; mem_adrs always equals pc.
- States:
  - IDLE: start=1 -> REQ with pc=RESET_PC.
  - REQ: mem_re_en=1 for exactly one cycle -> CAPT.
  - CAPT: the memory has registered data; sample mem_rdata at the end of CAPT.
    - Word equals HALT_WORD -> HALTED; instr_valid stays 0.
    - Otherwise instr<=mem_rdata, instr_pc<=pc, instr_valid<=1 -> HOLD.
  - HOLD: instr/instr_pc stable while instr_valid=1 and instr_ready=0.
    - On an edge with valid&&ready: fetch_cnt+1, pc<=pc+1, instr_valid<=0 -> REQ.
  - HALTED: halted=1, mem_re_en=0. Only rst leaves; start is ignored.
- Latency: start sampled at edge E0 gives mem_re_en=1 in cycle 1 and instr_valid=1 from cycle 3.
  - With ready held high, one instruction is delivered every 3 cycles.
- pc arithmetic: unsigned modulo 2^ADDR_W; 8191+1 wraps to 0, with no flag.
- redirect_valid:
  - In REQ, CAPT or HOLD: pc<=redirect_adrs, instr_valid<=0, next state REQ. Data in flight in CAPT is discarded, including a halt word.
  - In IDLE or HALTED: ignored.
  - Simultaneous with valid&&ready in HOLD: the transfer completes (fetch_cnt increments), then redirect_adrs is used instead of pc+1.
  - Takes priority over start.
- fetch_cnt saturates at all-ones.
- Mid-operation reset: any state returns to IDLE asynchronously. mem_re_en drops without waiting for a clock; a held instruction is lost.

Test Plan:
- Memory holds Mem[0]=0, Mem[1]=18'h08003, Mem[2]=18'h18001, Mem[3..11]=0, Mem[12]=18'h3FFFF; pulse start with instr_ready=1 -> delivers (pc,instr) (0,0), (1,08003), (2,18001), (3..11,0) at 3-cycle spacing; after address 12 is fetched, halted=1, instr_valid stays 0, fetch_cnt=12.
- instr_ready held 0 for 5 cycles after the first valid -> instr=0, instr_pc=0 stable; mem_re_en stays 0; transfer occurs on the first edge where ready=1.
- redirect_valid=1, redirect_adrs=12 in the cycle instr (1,08003) is accepted -> fetch_cnt increments; next mem_adrs=12; halted=1 with no further valid.
- redirect_valid pulsed during CAPT of address 12 with target 2 -> halt word is discarded; next delivered instruction is (2,18001).
- RESET_PC=8191 -> delivers address 8191, then mem_adrs wraps to 0.
- rst asserted mid-HOLD between clock edges -> instr_valid, mem_re_en, busy and fetch_cnt go to 0 immediately; start afterwards refetches address 0.
